// File: rtl/echo_cancel_sequencer_if.sv
// Handshake bundle between the echo-cancel sequencer and its datapath.
//   enable_cvt / enable_adapt / enable_cancel / enable_out : 1-cycle start strobes
//   out_sel        : output mux select (0 = error e, 1 = signal_without_echo)
//   ready_cvt_sig / ready_cvt_lag / ready_adapt / ready_cancel : level done flags
// master = sequencer side, slave = datapath side.
interface echo_cancel_sequencer_if;
  logic enable_cvt;
  logic enable_adapt;
  logic enable_cancel;
  logic enable_out;
  logic out_sel;
  logic ready_cvt_sig;
  logic ready_cvt_lag;
  logic ready_adapt;
  logic ready_cancel;

  modport master (
    output enable_cvt, enable_adapt, enable_cancel, enable_out, out_sel,
    input  ready_cvt_sig, ready_cvt_lag, ready_adapt, ready_cancel
  );

  modport slave (
    input  enable_cvt, enable_adapt, enable_cancel, enable_out, out_sel,
    output ready_cvt_sig, ready_cvt_lag, ready_adapt, ready_cancel
  );
endinterface

// File: rtl/echo_cancel_sequencer.sv
// Per-sample controller for the lag-16 echo-cancellation datapath.
// Once per sampling cycle it strobes the converters, the adaptive estimator
// (while adapting), the canceller and the output stage, waiting on each ready.
// Ports:
//   clk_operation, rst (sync active-high)
//   enable                  : run enable, sampled in IDLE only
//   sampling_cycle_counter  : value 0 starts a sample
//   dp (master modport)     : strobes, out_sel and ready levels
//   enable_sampling_adapt / enable_sampling_cancel : warm-up phase enables
//   adapt_active, iteration : adaptation state and completed adapt iterations
//   sample_cnt              : samples started (saturating)
//   busy, timeout_err       : not-IDLE flag, sticky timeout flag
// Optional feature macro ADAPT_RESTART_EN: adds input adapt_restart, which
// re-arms adaptation (applied in IDLE/HOLD, otherwise latched until HOLD).
module echo_cancel_sequencer #(
  parameter int unsigned WARM_CANCEL   = 2,
  parameter int unsigned WARM_ADAPT    = 4,
  parameter int unsigned ADAPT_SAMPLES = 100,
  parameter int unsigned READY_MASK    = 2,
  parameter int unsigned TIMEOUT       = 2000
) (
  input  logic                    clk_operation,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [12:0]             sampling_cycle_counter,
`ifdef ADAPT_RESTART_EN
  input  logic                    adapt_restart,
`endif
  echo_cancel_sequencer_if.master dp,
  output logic                    enable_sampling_adapt,
  output logic                    enable_sampling_cancel,
  output logic                    adapt_active,
  output logic [31:0]             iteration,
  output logic [15:0]             sample_cnt,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + READY_MASK + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_CVT, S_WAIT_CVT, S_ADAPT, S_WAIT_ADAPT,
    S_CANCEL, S_WAIT_CANCEL, S_OUT, S_HOLD
  } state_t;

  state_t              state;
  state_t              wait_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                waiting;
  logic                ready_sel;
  logic                accept;
  logic                expire;
  logic                start;
  logic                to_hold;
  logic                apply_restart;
  logic [15:0]         sample_cnt_new;
  logic [31:0]         iteration_new;

  // Which ready the current WAIT state listens to, and where it goes next
  always_comb begin
    waiting   = 1'b1;
    ready_sel = 1'b0;
    wait_next = S_HOLD;
    unique case (state)
      S_WAIT_CVT: begin
        ready_sel = dp.ready_cvt_sig & dp.ready_cvt_lag;
        wait_next = adapt_active ? S_ADAPT : S_CANCEL;
      end
      S_WAIT_ADAPT: begin
        ready_sel = dp.ready_adapt;
        wait_next = S_CANCEL;
      end
      S_WAIT_CANCEL: begin
        ready_sel = dp.ready_cancel;
        wait_next = S_OUT;
      end
      default: waiting = 1'b0;
    endcase
  end

  // Ready is ignored for READY_MASK cycles after the strobe (stale level from the previous sample)
  assign accept  = waiting && (wait_cnt >= WAIT_W'(READY_MASK)) && ready_sel;
  assign expire  = waiting && !accept && ((wait_cnt + WAIT_W'(1)) == WAIT_W'(TIMEOUT));
  assign start   = (state == S_IDLE) && enable && (sampling_cycle_counter == 13'd0);
  assign to_hold = (state == S_OUT) || expire;

  assign sample_cnt_new = (sample_cnt == 16'hFFFF) ? sample_cnt : sample_cnt + 16'd1;
  assign iteration_new  = iteration + 32'd1;

`ifdef ADAPT_RESTART_EN
  logic restart_pend;
  logic restart_now;

  assign restart_now   = adapt_restart && ((state == S_IDLE) || (state == S_HOLD));
  assign apply_restart = restart_now || (to_hold && (restart_pend || adapt_restart));

  // Restart requests arriving mid-sequence wait for the HOLD entry
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      restart_pend <= 1'b0;
    end else if (to_hold) begin
      restart_pend <= 1'b0;
    end else if (adapt_restart && !restart_now) begin
      restart_pend <= 1'b1;
    end
  end
`else
  assign apply_restart = 1'b0;
`endif

  // Sequencer FSM with registered strobes and status
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state                  <= S_IDLE;
      wait_cnt               <= '0;
      dp.enable_cvt          <= 1'b0;
      dp.enable_adapt        <= 1'b0;
      dp.enable_cancel       <= 1'b0;
      dp.enable_out          <= 1'b0;
      dp.out_sel             <= 1'b0;
      enable_sampling_adapt  <= 1'b0;
      enable_sampling_cancel <= 1'b0;
      adapt_active           <= 1'b1;
      iteration              <= 32'd0;
      sample_cnt             <= 16'd0;
      busy                   <= 1'b0;
      timeout_err            <= 1'b0;
    end else begin
      dp.enable_cvt    <= 1'b0;
      dp.enable_adapt  <= 1'b0;
      dp.enable_cancel <= 1'b0;
      dp.enable_out    <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state                  <= S_CVT;
            busy                   <= 1'b1;
            sample_cnt             <= sample_cnt_new;
            enable_sampling_cancel <= 32'(sample_cnt_new) > WARM_CANCEL;
            enable_sampling_adapt  <= 32'(sample_cnt_new) > WARM_ADAPT;
          end
        end
        S_CVT: begin
          dp.enable_cvt <= 1'b1;
          wait_cnt      <= '0;
          state         <= S_WAIT_CVT;
        end
        S_ADAPT: begin
          dp.enable_adapt <= 1'b1;
          wait_cnt        <= '0;
          state           <= S_WAIT_ADAPT;
        end
        S_CANCEL: begin
          dp.enable_cancel <= 1'b1;
          wait_cnt         <= '0;
          state            <= S_WAIT_CANCEL;
        end
        S_WAIT_CVT, S_WAIT_ADAPT, S_WAIT_CANCEL: begin
          if (accept) begin
            state <= wait_next;
          end else if (expire) begin
            timeout_err <= 1'b1;
            state       <= S_HOLD;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_OUT: begin
          dp.enable_out <= 1'b1;
          dp.out_sel    <= ~adapt_active;
          if (adapt_active) begin
            iteration <= iteration_new;
            // Freeze takes effect from the next sample
            if (iteration_new == ADAPT_SAMPLES) adapt_active <= 1'b0;
          end
          state <= S_HOLD;
        end
        S_HOLD: begin
          // Leave only once the counter moves on, so one sample never triggers twice
          if (sampling_cycle_counter != 13'd0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (apply_restart) begin
        adapt_active <= 1'b1;
        iteration    <= 32'd0;
      end
    end
  end

endmodule

// File: doc/echo_cancel_sequencer.md
Name: echo_cancel_sequencer

Overview:
- Per-sample controller for the lag-16 echo-cancellation datapath: the two sig16b-to-double converters, the adaptive parameter estimator, the echo canceller and the double-to-sig16b output stage.
- Replaces delay-based sequencing with a ready-driven FSM triggered once per sampling cycle.
- Owns warm-up phasing (sampling enables), the adapt-then-freeze mode switch, the iteration count and timeout detection.

Parameters:
- WARM_CANCEL, default 2: samples after reset before enable_sampling_cancel rises.
- WARM_ADAPT, default 4: samples after reset before enable_sampling_adapt rises; must be ≥ WARM_CANCEL.
- ADAPT_SAMPLES, default 100: completed adapt iterations before the estimator is frozen.
- READY_MASK, default 2: cycles after a strobe during which ready is ignored (stale-ready guard).
- TIMEOUT, default 2000: maximum cycles waiting on any single ready.

Ports:
- clk_operation  in  1  operation clock
- rst  in  1  synchronous active-high reset
- enable  in  1  global run enable; sampled only in IDLE
- sampling_cycle_counter  in  13  sample-phase counter; value 0 starts a sample
- ready_cvt_sig  in  1  signal converter done (level)
- ready_cvt_lag  in  1  lagged-signal converter done (level)
- ready_adapt  in  1  parameter estimator done (level)
- ready_cancel  in  1  canceller done (level)
- enable_cvt  out  1  1-cycle start strobe to both converters
- enable_adapt  out  1  1-cycle start strobe to estimator
- enable_cancel  out  1  1-cycle start strobe to canceller
- enable_out  out  1  1-cycle load strobe to output converter
- out_sel  out  1  output mux select: 0 = error e, 1 = signal_without_echo
- enable_sampling_adapt  out  1  estimator sampling enable
- enable_sampling_cancel  out  1  canceller sampling enable
- adapt_active  out  1  1 while adaptation is running
- iteration  out  32  completed adapt iterations
- sample_cnt  out  16  samples started since reset; saturates at 65535
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set on any timeout

Behaviour:
- Reset values (rst high at a clock edge): all strobes 0, out_sel 0, both sampling enables 0, adapt_active 1, iteration 0, sample_cnt 0, busy 0, timeout_err 0, state IDLE, wait counter 0. Reset mid-sequence aborts on that edge with no further strobes.
- IDLE: move to CVT when enable=1 and sampling_cycle_counter==0. On the same edge, sample_cnt increments and the phase enables are recomputed:
  - enable_sampling_cancel = (sample_cnt_new > WARM_CANCEL)
  - enable_sampling_adapt = (sample_cnt_new > WARM_ADAPT)
- CVT: enable_cvt=1 for one cycle, then WAIT_CVT.
- WAIT_CVT: wait counter restarts at each strobe. Ready is ignored for READY_MASK cycles, then the state waits for ready_cvt_sig & ready_cvt_lag.
  - adapt_active=1: go to ADAPT.
  - adapt_active=0: go to CANCEL.
- ADAPT: enable_adapt pulse, then WAIT_ADAPT (same masking rule). On ready_adapt, go to CANCEL.
- CANCEL: enable_cancel pulse, then WAIT_CANCEL. On ready_cancel, go to OUT.
- OUT: enable_out pulse, with out_sel = ~adapt_active held on the same cycle.
  - If adapt_active=1, iteration increments.
  - If iteration_new == ADAPT_SAMPLES, adapt_active clears on this edge, so the freeze takes effect from the next sample.
  - Then go to HOLD.
- HOLD: wait until sampling_cycle_counter != 0, then IDLE. This prevents a double trigger within one sample.
- Timeout: when the wait counter reaches TIMEOUT in any WAIT state, set timeout_err, issue no further strobes, skip OUT and go to HOLD. iteration does not change.
- Overrun: sampling_cycle_counter==0 while busy is ignored; the sample is dropped and sample_cnt does not increment.
- enable=0 mid-sequence: the current sample completes; no new sample starts.
- Strobes are mutually exclusive; at most one is high in any cycle.
- iteration wraps modulo 2^32.
- Minimum latency IDLE→enable_out, all readies already high after the mask:
  - adapt mode: 3×(1+READY_MASK+1) + 1 cycles.
  - cancel-only mode: 2×(1+READY_MASK+1) + 1 cycles.

Optional Feature:
- Macro ADAPT_RESTART_EN.
- Defined: adds input adapt_restart (1 bit). A pulse in IDLE or HOLD sets adapt_active=1 and iteration=0, so adaptation reruns for ADAPT_SAMPLES samples. A pulse in any other state is latched and applied on entry to HOLD.
- Undefined: no port; the freeze is permanent until rst.

Test Plan:
- Reset, enable=1, readies tied high, READY_MASK=2 → per sample: enable_cvt, enable_adapt, enable_cancel, enable_out in order; enable_out lands exactly 13 cycles after leaving IDLE; out_sel=0.
- Run 6 samples, WARM_CANCEL=2, WARM_ADAPT=4 → enable_sampling_cancel rises on sample 3 and enable_sampling_adapt on sample 5.
- ADAPT_SAMPLES=3 → iteration reaches 3, adapt_active falls; sample 4 shows no enable_adapt, out_sel=1, iteration stays 3.
- ready_adapt held low, TIMEOUT=50 → timeout_err=1 at 50 wait cycles, no enable_cancel or enable_out, FSM in IDLE after the counter leaves 0.
- sampling_cycle_counter wraps to 0 while busy → no extra enable_cvt, sample_cnt unchanged; rst asserted in WAIT_CANCEL → all outputs at reset values next cycle.
- ADAPT_RESTART_EN defined, pulse adapt_restart after freeze → iteration=0, adapt_active=1, the next sample issues enable_adapt.
